// File: rtl/reg_read_pkg.sv
// reg_read_pkg: shared types and defaults for the round-robin register read arbiter.
package reg_read_pkg;
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_SEL_W  = 3;
    localparam int OOR_VALUE  = 0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);
    logic found;
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found                      = 1'b1;
                idx                        = IDX_W'((int'(ptr) + i) % N);
                gnt[(int'(ptr) + i) % N]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter: round-robin register read arbiter, IDLE -> READ (grant) -> RESP (valid).
// Define REG_READ_BYPASS_EN to forward a same-cycle register write into the READ capture.
module reg_read_arbiter
    import reg_read_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NUM_REGS  = 8,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CORES-1:0]       rd_req,
    input  logic [NUM_CORES*SEL_W-1:0] rd_sel,
    input  logic [NUM_REGS*DATA_W-1:0] reg_bank,
`ifdef REG_READ_BYPASS_EN
    input  logic                       wr_en,
    input  logic [SEL_W-1:0]           wr_sel,
    input  logic [DATA_W-1:0]          wr_data,
`endif
    output logic [NUM_CORES-1:0]       rd_gnt,
    output logic [NUM_CORES-1:0]       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy
);
    localparam int IDX_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;

    state_t               state;
    logic [IDX_W-1:0]     ptr, win_idx, pick_idx;
    logic [NUM_CORES-1:0] pick_oh;
    logic [SEL_W-1:0]     win_sel;
    logic [DATA_W-1:0]    bank_val, cap_val;

    rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_rr (
        .req (rd_req),
        .ptr (ptr),
        .gnt (pick_oh),
        .idx (pick_idx)
    );

    assign bank_val = int'(win_sel) < NUM_REGS ? reg_bank[int'(win_sel)*DATA_W +: DATA_W] : DATA_W'(OOR_VALUE);
`ifdef REG_READ_BYPASS_EN
    assign cap_val = (wr_en && wr_sel == win_sel) ? wr_data : bank_val;
`else
    assign cap_val = bank_val;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_gnt   <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            win_idx  <= '0;
            win_sel  <= '0;
        end else begin
            case (state)
                IDLE: if (|rd_req) begin
                    state   <= READ;
                    rd_gnt  <= pick_oh;
                    win_idx <= pick_idx;
                    win_sel <= rd_sel[int'(pick_idx)*SEL_W +: SEL_W];
                    busy    <= 1'b1;
                end
                READ: begin
                    state    <= RESP;
                    rd_gnt   <= '0;
                    rd_valid <= rd_gnt;
                    rd_data  <= cap_val;
                end
                RESP: begin
                    state    <= IDLE;
                    rd_valid <= '0;
                    busy     <= 1'b0;
                    ptr      <= (win_idx == IDX_W'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_read_arbiter.sv
// tb_reg_read_arbiter: directed and randomized checks of reg_read_arbiter against a transaction-level model.
module tb_reg_read_arbiter;
    localparam int NC = 4, NR = 6, DW = 16, SW = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NC-1:0]    rd_req = '0;
    logic [NC*SW-1:0] rd_sel = '0;
    logic [NR*DW-1:0] reg_bank = '0;
    logic [NC-1:0]    rd_gnt, rd_valid;
    logic [DW-1:0]    rd_data;
    logic             busy;
`ifdef REG_READ_BYPASS_EN
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_sel = '0;
    logic [DW-1:0] wr_data = '0;
`endif

    reg_read_arbiter #(.NUM_CORES(NC), .NUM_REGS(NR), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .reg_bank (reg_bank),
`ifdef REG_READ_BYPASS_EN
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
`endif
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ptr_m = 0;
    int valid_cnt [NC];
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] bank_m [NR];
    logic [SW-1:0] sel_m [NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int c = 0; c < NC; c++) rd_sel[c*SW +: SW] = sel_m[c];
        for (int j = 0; j < NR; j++) reg_bank[j*DW +: DW] = bank_m[j];
    endtask

    function automatic int pick(input logic [NC-1:0] r);
        for (int k = 0; k < NC; k++)
            if (r[(ptr_m + k) % NC]) return (ptr_m + k) % NC;
        return -1;
    endfunction

    function automatic logic [DW-1:0] model_data(input int s);
        return s < NR ? bank_m[s] : '0;
    endfunction

    task automatic new_reqs();
        for (int c = 0; c < NC; c++)
            if (!rd_req[c] && $urandom_range(0, 1) == 1) begin
                rd_req[c] = 1'b1;
                sel_m[c]  = SW'($urandom_range(0, 7));
            end
        drive();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_gnt"}, rd_gnt, 0);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, rd_data, last_data);
    endtask

    // One full request/grant/valid exchange; the current rd_req must be nonzero.
    task automatic txn(input bit hold, input bit add_new);
        int w;
        logic [DW-1:0] exp_d;
        w = pick(rd_req);
        exp_d = model_data(int'(sel_m[w]));
        tick();
        chk("gnt", rd_gnt, 32'(1) << w);
        chk("gnt_cycle_valid", rd_valid, 0);
        chk("gnt_cycle_busy", busy, 1);
        chk("gnt_cycle_data_hold", rd_data, last_data);
        if (!hold) rd_req[w] = 1'b0;
        if (add_new) new_reqs();
        tick();
        chk("valid", rd_valid, 32'(1) << w);
        chk("valid_cycle_gnt", rd_gnt, 0);
        chk("valid_cycle_busy", busy, 1);
        chk("data", rd_data, exp_d);
        for (int c = 0; c < NC; c++) if (rd_valid[c]) valid_cnt[c]++;
        last_data = exp_d;
        ptr_m = (w + 1) % NC;
        tick();
        check_idle("post_txn");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        last_data = '0;
        check_idle("reset");
    endtask

    initial begin
        for (int j = 0; j < NR; j++) bank_m[j] = '0;
        for (int c = 0; c < NC; c++) begin
            sel_m[c] = '0;
            valid_cnt[c] = 0;
        end
        drive();
        tick();
        do_reset();

        // single read: core1 reads reg 2
        bank_m[2] = 16'hBEEF;
        sel_m[1] = 3'd2;
        rd_req = 4'b0010;
        drive();
        txn(0, 0);

        // contention from pointer 0: core0 then core3, pointer wraps to 0
        do_reset();
        bank_m[1] = 16'h1111;
        bank_m[5] = 16'h5555;
        sel_m[0] = 3'd1;
        sel_m[3] = 3'd5;
        rd_req = 4'b1001;
        drive();
        txn(0, 0);
        txn(0, 0);

        // fairness: all cores request continuously, order follows the wrapped pointer
        for (int c = 0; c < NC; c++) begin
            valid_cnt[c] = 0;
            sel_m[c] = SW'(c);
            bank_m[c] = DW'(16'hA000 + c);
        end
        rd_req = 4'b1111;
        drive();
        for (int t = 0; t < NC; t++) txn(1, 0);
        rd_req = '0;
        for (int c = 0; c < NC; c++) chk("fair_valid_count", valid_cnt[c], 1);
        tick();
        check_idle("idle_no_req");

        // out-of-range selects read as zero
        sel_m[2] = 3'd7;
        rd_req = 4'b0100;
        drive();
        txn(0, 0);
        sel_m[0] = 3'd6;
        rd_req = 4'b0001;
        drive();
        txn(0, 0);

        // reset during READ drops the transaction
        bank_m[3] = 16'h1234;
        sel_m[1] = 3'd3;
        rd_req = 4'b0010;
        drive();
        tick();
        chk("rst_mid_gnt", rd_gnt, 4'b0010);
        rd_req = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        last_data = '0;
        check_idle("rst_mid");
        for (int t = 0; t < 3; t++) begin
            tick();
            check_idle("rst_mid_after");
        end

        // same-cycle write during READ
        bank_m[4] = 16'h0001;
        sel_m[0] = 3'd4;
        rd_req = 4'b0001;
        drive();
        tick();
        chk("byp_gnt", rd_gnt, 4'b0001);
        rd_req = '0;
`ifdef REG_READ_BYPASS_EN
        wr_en = 1'b1;
        wr_sel = 3'd4;
        wr_data = 16'h00AA;
        last_data = 16'h00AA;
`else
        last_data = 16'h0001;
`endif
        tick();
`ifdef REG_READ_BYPASS_EN
        wr_en = 1'b0;
`endif
        chk("byp_valid", rd_valid, 4'b0001);
        chk("byp_data", rd_data, last_data);
        ptr_m = 1;
        tick();
        check_idle("byp_idle");

        // randomized traffic with held losers and fresh requests
        for (int it = 0; it < 60; it++) begin
            for (int j = 0; j < NR; j++) bank_m[j] = DW'($urandom);
            if ($urandom_range(0, 3) != 0) new_reqs();
            else drive();
            if (rd_req == '0) begin
                tick();
                check_idle("rand_idle");
            end else begin
                txn(0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
